// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one bit4Adder is reused for WIDTH/4 cycles, LSB nibble first, with a rippled carry register.
// Optional subtract mode (a - b) is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN, which adds the sub port.

module bit4Adder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] sum_c,
   output logic       cout_c
);

   // Plain 4-bit ripple: carry travels bit by bit, no lookahead.
   always_comb begin
      logic carry;
      carry = c_i;
      sum_c = '0;
      for (int i = 0; i < 4; i++) begin
         sum_c[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_c = carry;
   end

endmodule

module nibble_serial_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int unsigned NIBBLES  = WIDTH / 4;
   localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned BASE_W   = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               sub_c;
   logic [BASE_W-1:0]  base_c;
   logic [3:0]         a_nib_c;
   logic [3:0]         b_nib_c;
   logic [3:0]         nib_sum_c;
   logic               nib_cout_c;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   assign sub_c = sub;
`else
   assign sub_c = 1'b0;
`endif

   // Current nibble of each operand; b_q already holds the operand actually added (b or ~b).
   assign base_c  = {idx_q, 2'b00};
   assign a_nib_c = a_q[base_c +: 4];
   assign b_nib_c = b_q[base_c +: 4];

   bit4Adder u_nib_add (
      .a_i    (a_nib_c),
      .b_i    (b_nib_c),
      .c_i    (carry_q),
      .sum_c  (nib_sum_c),
      .cout_c (nib_cout_c)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub_c ? ~b : b;
               carry_d = sub_c | c_in;
               idx_d   = '0;
               sum_d   = '0;
               c_out_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[base_c +: 4] = nib_sum_c;
            carry_d            = nib_cout_c;
            idx_d              = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Top nibble bit 3 is the operand/result MSB, so signed overflow is decided here.
               c_out_d = nib_cout_c;
               ovf_d   = (a_nib_c[3] == b_nib_c[3]) && (nib_sum_c[3] != a_nib_c[3]);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: stimulus pushes model results, a negedge monitor pops them on done.
module tb_nibble_serial_adder;

   localparam int unsigned W   = 32;
   localparam int unsigned NIB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         c_in = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   logic         sub_s = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         overflow;

   exp_t         exp_q[$];
   exp_t         e_m;
   logic [W+1:0] hold = '0;
   int           busy_cnt = 0;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_bad = 0;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      .sub      (sub_s),
`endif
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .c_out    (c_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Reference: whole-word arithmetic on the operand actually added.
   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, input logic ts);
      exp_t         m;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb     = ts ? ~tb : tb;
      full   = {1'b0, ta} + {1'b0, bb} + (W+1)'(ts ? 1'b1 : tc);
      m.sum  = full[W-1:0];
      m.cout = full[W];
      m.ovf  = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
      m.cyc  = 0;
      return m;
   endfunction

   // Monitor: compare on done, check result hold while idle, flush on reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold     = '0;
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'(0));
            end else begin
               e_m = exp_q.pop_front();
               chk("sum", 64'(sum), 64'(e_m.sum));
               chk("c_out", 64'(c_out), 64'(e_m.cout));
               chk("overflow", 64'(overflow), 64'(e_m.ovf));
               chk("done_cycle", 64'(cyc), 64'(e_m.cyc));
               chk("busy_len", 64'(busy_cnt), 64'(NIB));
               chk("busy_in_done", 64'(busy), 64'(0));
               hold = {e_m.sum, e_m.cout, e_m.ovf};
            end
            busy_cnt = 0;
         end else if (!busy) begin
            chk("idle_hold", 64'({sum, c_out, overflow}), 64'(hold));
         end
      end
   end

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
      exp_t e;
      a     = ta;
      b     = tb;
      c_in  = tc;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sub_s = ts;
`endif
      start = 1'b1;
      e     = model(ta, tb, tc, ts);
      e.cyc = cyc + 1 + NIB;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) chk("ready_timeout", 64'(busy), 64'(0));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) chk("done_timeout", 64'(done), 64'(1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return W'(32'h7FFF_FFFF);
         2:       return W'(32'h8000_0000);
         default: return W'($urandom());
      endcase
   endfunction

   initial begin
      // Reset with start held high: must not be accepted.
      rst_n = 1'b0;
      a     = W'(32'hDEAD_BEEF);
      b     = W'(32'h1234_5678);
      start = 1'b1;
      idle(3);
      start = 1'b0;
      rst_n = 1'b1;
      idle(3);

      issue(W'(32'hFFFF_FFFF), W'(32'h0000_0001), 1'b0, 1'b0);
      wait_ready();
      idle(2);
      issue(W'(32'h7FFF_FFFF), W'(32'h0000_0001), 1'b0, 1'b0);
      wait_ready();
      idle(1);

      // Second start mid-RUN with other operands is ignored.
      issue(W'(32'h1234_5678), W'(32'h1111_1111), 1'b1, 1'b0);
      idle(1);
      a     = W'(32'hAAAA_AAAA);
      b     = W'(32'h5555_5555);
      c_in  = 1'b0;
      start = 1'b1;
      idle(1);
      start = 1'b0;
      wait_ready();
      idle(2);

      // Reset mid-RUN aborts: no done, outputs zero.
      issue(W'(32'h0F0F_0F0F), W'(32'h0101_0101), 1'b0, 1'b0);
      idle(2);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(12);

      // Back-to-back: second start in the DONE cycle.
      issue(W'(32'h0000_00FF), W'(32'h0000_0001), 1'b0, 1'b0);
      wait_done();
      issue(W'(32'h8000_0000), W'(32'h8000_0000), 1'b1, 1'b0);
      wait_ready();
      idle(1);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      issue(W'(5), W'(7), 1'b0, 1'b1);
      wait_ready();
      idle(1);
      issue(W'(32'h8000_0000), W'(1), 1'b1, 1'b1);
      wait_ready();
      idle(1);
`endif

      for (int i = 0; i < 30; i++) begin
         wait_ready();
         if ($urandom_range(0, 2) == 0) begin
            wait_done();
         end else begin
            idle($urandom_range(0, 2));
         end
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
         issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
         issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
`endif
      end
      wait_ready();
      idle(4);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits. It SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1: request to begin an add; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  WIDTH: operand A; captured on an accepted start.
REQ-006 SHALL have port b  input  WIDTH: operand B; captured on an accepted start.
REQ-007 SHALL have port c_in  input  1: carry-in to nibble 0; captured on an accepted start.
REQ-008 SHALL have port busy  output  1: high while in RUN.
REQ-009 SHALL have port done  output  1: one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum  output  WIDTH: registered result.
REQ-011 SHALL have port c_out  output  1: carry out of the MSB nibble.
REQ-012 SHALL have port overflow  output  1: signed two's-complement overflow of the result.

Function
REQ-013 SHALL compute each nibble with one instance of the existing bit4Adder cell, fed from the current operand nibbles and the registered carry.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE; reset SHALL enter IDLE.
REQ-015 SHALL, in IDLE or DONE with start=1, capture a, b and c_in, clear the nibble index, clear sum, and enter RUN on the next cycle.
REQ-016 SHALL, in RUN, write nibble k of sum, update the carry register, and increment k once per cycle, least-significant nibble first.
REQ-017 SHALL leave RUN for DONE after nibble WIDTH/4-1 is written; the carry out of that nibble SHALL become c_out.
REQ-018 SHALL make overflow = (A[MSB]==B'[MSB]) and (sum[MSB]!=A[MSB]), where B' is the operand actually added.
REQ-019 SHALL assert done only in DONE, for exactly one cycle; without a new start, DONE SHALL return to IDLE.
REQ-020 SHALL give fixed latency: start accepted at edge 0, busy high for WIDTH/4 cycles, done high in cycle WIDTH/4+1 (cycle 9 for WIDTH=32).
REQ-021 SHALL hold sum, c_out and overflow stable from done until the next accepted start.
REQ-022 SHALL ignore start while in RUN; operands SHALL NOT change mid-operation.
REQ-023 SHALL accept start in the DONE cycle back-to-back: done is still 1 in that cycle, and RUN begins next cycle.
REQ-024 SHALL keep the carry-in for nibble k+1 equal to the carry-out of nibble k; there SHALL be no carry lookahead.

Reset
REQ-025 SHALL, with rst_n=0 at a clock edge, force state=IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, nibble index=0, carry=0 and operand registers=0.
REQ-026 SHALL let reset asserted mid-RUN abort the operation; no done pulse SHALL follow.
REQ-027 SHALL ignore start on any edge where rst_n=0.

Configuration
REQ-028 SHALL, when macro NIBBLE_SERIAL_ADDER_SUB_EN is defined, add port sub  input  1, captured on start. When sub=1, B' SHALL be ~b and the initial carry SHALL be 1, ignoring c_in, giving a - b.
REQ-029 SHALL, when NIBBLE_SERIAL_ADDER_SUB_EN is undefined, have no sub port, with B'=b and initial carry=c_in.

Verification
REQ-030 SHALL cover: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1, overflow=0, done in cycle 9.
REQ-031 SHALL cover: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, c_out=0, overflow=1.
REQ-032 SHALL cover: a=0x12345678, b=0x11111111, c_in=1, then start pulsed with new operands at cycle 3 -> sum=0x2345678A, second start ignored.
REQ-033 SHALL cover: start accepted, rst_n=0 at cycle 4 -> all outputs 0, no done pulse, state IDLE.
REQ-034 SHALL cover: back-to-back starts (second start in the DONE cycle) -> two done pulses 9 cycles apart with correct sums.
REQ-035 SHALL cover, with NIBBLE_SERIAL_ADDER_SUB_EN defined: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0, overflow=0.
